// File: rtl/fwd_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_scoreboard_if
//  Description : Bundles stage results, source operands, issue and multi-cycle
//                signals exchanged with the forwarding/hazard unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fwd_scoreboard_if #(
    parameter int XLEN = 32,
    parameter int NSRC = 2,
    parameter int NFWD = 3
);
    logic [NFWD-1:0]      stg_wr;
    logic [5*NFWD-1:0]    stg_rd;
    logic [NFWD-1:0]      stg_rdy;
    logic [XLEN*NFWD-1:0] stg_data;
    logic [5*NSRC-1:0]    src_rs;
    logic [NSRC-1:0]      src_use;
    logic [XLEN*NSRC-1:0] src_rf;
    logic                 id_valid;
    logic                 id_wr;
    logic [4:0]           id_rd;
    logic                 id_mc;
    logic                 mc_done;
    logic [4:0]           mc_rd;
    logic [XLEN-1:0]      mc_data;
    logic                 mc_flush;
    logic [XLEN*NSRC-1:0] fw_data;
    logic                 stall;
    logic [2:0]           stall_why;
    logic [31:0]          stall_cnt;
    logic [31:0]          sb_busy;
    logic                 sb_err;

    modport master (
        output stg_wr, stg_rd, stg_rdy, stg_data, src_rs, src_use, src_rf,
               id_valid, id_wr, id_rd, id_mc, mc_done, mc_rd, mc_data, mc_flush,
        input  fw_data, stall, stall_why, stall_cnt, sb_busy, sb_err
    );

    modport slave (
        input  stg_wr, stg_rd, stg_rdy, stg_data, src_rs, src_use, src_rf,
               id_valid, id_wr, id_rd, id_mc, mc_done, mc_rd, mc_data, mc_flush,
        output fw_data, stall, stall_why, stall_cnt, sb_busy, sb_err
    );
endinterface
`default_nettype wire

// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_scoreboard
//  Description : Operand forwarding, load/multi-cycle/WAW hazard detection and
//                a registered multi-cycle scoreboard with watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_scoreboard #(
    parameter int XLEN    = 32,
    parameter int NSRC    = 2,
    parameter int NFWD    = 3,
    parameter int TIMEOUT = 64
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    fwd_scoreboard_if.slave   bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [31:0]     sb_busy_q, sb_busy_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            sb_err_q, sb_err_d;

    logic [NSRC-1:0] w_load_raw;
    logic [NSRC-1:0] w_mc_raw;
    logic            w_waw;
    logic            w_stall;
    logic            w_set;

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        logic [4:0]      w_rs;
        logic            w_mc_hit;
        logic            w_stg_hit;
        logic            w_stg_rdy;
        logic [XLEN-1:0] w_stg_data;
        logic [XLEN-1:0] w_fw;

        assign w_rs     = bus.src_rs[5*s +: 5];
        assign w_mc_hit = bus.mc_done && (bus.mc_rd == w_rs);

        // Scan oldest to youngest so the youngest matching stage wins.
        always_comb begin
            w_stg_hit  = 1'b0;
            w_stg_rdy  = 1'b1;
            w_stg_data = bus.src_rf[XLEN*s +: XLEN];
            for (int i = NFWD - 1; i >= 0; i--) begin
                if (bus.stg_wr[i] && (bus.stg_rd[5*i +: 5] == w_rs)) begin
                    w_stg_hit  = 1'b1;
                    w_stg_rdy  = bus.stg_rdy[i];
                    w_stg_data = bus.stg_data[XLEN*i +: XLEN];
                end
            end
        end

        always_comb begin
            w_fw = w_stg_data;
            if (w_rs == 5'd0) begin
                w_fw = '0;
            end else if (w_mc_hit) begin
                w_fw = bus.mc_data;
            end
        end

        assign bus.fw_data[XLEN*s +: XLEN] = w_fw;
        assign w_load_raw[s] = bus.src_use[s] && (w_rs != 5'd0) && !w_mc_hit
                               && w_stg_hit && !w_stg_rdy;
        assign w_mc_raw[s]   = bus.src_use[s] && sb_busy_q[w_rs] && !w_mc_hit;
    end

    assign w_waw   = bus.id_wr && sb_busy_q[bus.id_rd]
                     && !(bus.mc_done && (bus.mc_rd == bus.id_rd));
    assign w_stall = bus.id_valid && ((|w_load_raw) || (|w_mc_raw) || w_waw);
    assign w_set   = bus.id_valid && !w_stall && bus.id_wr && bus.id_mc
                     && (bus.id_rd != 5'd0);

    assign bus.stall     = w_stall;
    assign bus.stall_why = {w_waw, |w_mc_raw, |w_load_raw} & {3{bus.id_valid}};
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.sb_busy   = sb_busy_q;
    assign bus.sb_err    = sb_err_q;

    // Set is applied after clear so a re-issue wins over a same-cycle completion.
    always_comb begin
        sb_busy_d = sb_busy_q;
        if (bus.mc_flush) begin
            sb_busy_d = '0;
        end else begin
            if (bus.mc_done) begin
                sb_busy_d[bus.mc_rd] = 1'b0;
            end
            if (w_set) begin
                sb_busy_d[bus.id_rd] = 1'b1;
            end
        end
        sb_busy_d[0] = 1'b0;
    end

    always_comb begin
        wd_d = wd_q;
        if (bus.mc_flush || bus.mc_done || (sb_busy_q == 32'd0)) begin
            wd_d = '0;
        end else if (wd_q != WD_W'(TIMEOUT)) begin
            wd_d = wd_q + 1'b1;
        end
        sb_err_d = sb_err_q || (wd_d == WD_W'(TIMEOUT));
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (w_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sb_busy_q   <= '0;
            stall_cnt_q <= '0;
            wd_q        <= '0;
            sb_err_q    <= 1'b0;
        end else begin
            sb_busy_q   <= sb_busy_d;
            stall_cnt_q <= stall_cnt_d;
            wd_q        <= wd_d;
            sb_err_q    <= sb_err_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fwd_scoreboard
//  Description : Directed and randomized bench for fwd_scoreboard against a
//                behavioural operand/hazard/scoreboard model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_scoreboard;
    localparam int XLEN    = 32;
    localparam int NSRC    = 2;
    localparam int NFWD    = 3;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fwd_scoreboard_if #(.XLEN(XLEN), .NSRC(NSRC), .NFWD(NFWD)) bus ();

    fwd_scoreboard #(.XLEN(XLEN), .NSRC(NSRC), .NFWD(NFWD), .TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int npass  = 0;
    int ntotal = 0;

    bit          mbusy [32];
    longint      mcnt;
    int          mwd;
    bit          merr;
    bit          e_stall;
    logic [2:0]  e_why;
    logic [31:0] e_fw [NSRC];
    bit          e_dc [NSRC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = mbusy[i];
        return v;
    endfunction

    // First-match operand rules and hazard terms evaluated from the current inputs.
    task automatic model_eval();
        bit load = 0, mcr = 0, waw;
        for (int s = 0; s < NSRC; s++) begin
            int rs = int'(bus.src_rs[5*s +: 5]);
            bit mch = bus.mc_done && (int'(bus.mc_rd) == rs);
            bit found = 0;
            e_dc[s] = 0;
            e_fw[s] = bus.src_rf[XLEN*s +: XLEN];
            if (rs == 0) e_fw[s] = 0;
            else if (mch) e_fw[s] = bus.mc_data;
            else begin
                for (int i = 0; i < NFWD; i++) begin
                    if (!found && bus.stg_wr[i] && int'(bus.stg_rd[5*i +: 5]) == rs) begin
                        found = 1;
                        if (bus.stg_rdy[i]) e_fw[s] = bus.stg_data[XLEN*i +: XLEN];
                        else begin
                            e_dc[s] = 1;
                            if (bus.src_use[s]) load = 1;
                        end
                    end
                end
            end
            if (bus.src_use[s] && mbusy[rs] && !mch) mcr = 1;
        end
        waw = bus.id_wr && mbusy[bus.id_rd] && !(bus.mc_done && bus.mc_rd == bus.id_rd);
        e_stall = bus.id_valid && (load || mcr || waw);
        e_why   = bus.id_valid ? {waw, mcr, load} : 3'b000;
    endtask

    task automatic check(input string tag);
        model_eval();
        for (int s = 0; s < NSRC; s++)
            if (!e_dc[s]) chk({tag, ".fw"}, bus.fw_data[XLEN*s +: XLEN], e_fw[s]);
        chk({tag, ".stall"},   32'(bus.stall), 32'(e_stall));
        chk({tag, ".why"},     32'(bus.stall_why), 32'(e_why));
        chk({tag, ".busy"},    bus.sb_busy, busy_vec());
        chk({tag, ".cnt"},     bus.stall_cnt, mcnt[31:0]);
        chk({tag, ".err"},     32'(bus.sb_err), 32'(merr));
    endtask

    task automatic tick();
        bit empty = 1;
        model_eval();
        for (int i = 0; i < 32; i++) if (mbusy[i]) empty = 0;
        if (rst) begin
            for (int i = 0; i < 32; i++) mbusy[i] = 0;
            mcnt = 0; mwd = 0; merr = 0;
        end else begin
            if (e_stall && mcnt < 64'hFFFF_FFFF) mcnt++;
            if (bus.mc_flush || bus.mc_done || empty) mwd = 0;
            else if (mwd < TIMEOUT) mwd++;
            if (mwd >= TIMEOUT) merr = 1;
            if (bus.mc_flush) begin
                for (int i = 0; i < 32; i++) mbusy[i] = 0;
            end else begin
                if (bus.mc_done) mbusy[bus.mc_rd] = 0;
                if (bus.id_valid && !e_stall && bus.id_wr && bus.id_mc && bus.id_rd != 0)
                    mbusy[bus.id_rd] = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stg_wr = '0; bus.stg_rd = '0; bus.stg_rdy = '1; bus.stg_data = '0;
        bus.src_rs = '0; bus.src_use = '0; bus.src_rf = {32'hAAAA_0001, 32'hAAAA_0000};
        bus.id_valid = 0; bus.id_wr = 0; bus.id_rd = 0; bus.id_mc = 0;
        bus.mc_done = 0; bus.mc_rd = 0; bus.mc_data = '0; bus.mc_flush = 0;
    endtask

    task automatic issue_mc(input logic [4:0] rd);
        idle();
        bus.id_valid = 1; bus.id_wr = 1; bus.id_mc = 1; bus.id_rd = rd;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mbusy[i] = 0;
        mcnt = 0; mwd = 0; merr = 0;
        idle();
        #1;
        tick(); tick();
        check("reset");
        chk("reset.busy0", bus.sb_busy, 32'd0);
        chk("reset.cnt0", bus.stall_cnt, 32'd0);
        rst = 0;

        // Forwarding priority and x0
        idle();
        bus.stg_wr = 3'b111; bus.stg_rd = {5'd5, 5'd5, 5'd5}; bus.stg_rdy = 3'b111;
        bus.stg_data = {32'h33, 32'h22, 32'h11};
        bus.src_rs = {5'd0, 5'd5}; bus.src_use = 2'b01; bus.id_valid = 1;
        #1; check("fwd");
        chk("fwd.youngest", bus.fw_data[31:0], 32'h11);
        bus.src_rs = {5'd0, 5'd0};
        #1; check("fwd.x0");
        chk("fwd.x0val", bus.fw_data[31:0], 32'h0);
        tick();

        // Load-use with no fall-through
        idle();
        bus.stg_wr = 3'b011; bus.stg_rd = {5'd0, 5'd7, 5'd7}; bus.stg_rdy = 3'b110;
        bus.stg_data = {32'h0, 32'h77, 32'h66};
        bus.src_rs = {5'd7, 5'd0}; bus.src_use = 2'b10; bus.id_valid = 1;
        #1; check("lu");
        chk("lu.stall", 32'(bus.stall), 32'd1);
        chk("lu.why", 32'(bus.stall_why), 32'b001);
        tick();
        bus.src_use = 2'b00;
        #1; check("lu.nouse");
        tick();

        // Multi-cycle RAW
        issue_mc(5'd9);
        #1; check("mc.issue"); tick();
        chk("mc.busy9", bus.sb_busy, 32'h200);
        idle();
        bus.id_valid = 1; bus.src_rs = {5'd0, 5'd9}; bus.src_use = 2'b01;
        for (int k = 0; k < 3; k++) begin
            #1; check("mc.wait");
            chk("mc.why", 32'(bus.stall_why), 32'b010);
            tick();
        end
        bus.mc_done = 1; bus.mc_rd = 5'd9; bus.mc_data = 32'hDEAD;
        #1; check("mc.done");
        chk("mc.fwd", bus.fw_data[31:0], 32'hDEAD);
        tick();
        bus.mc_done = 0;
        #1; check("mc.clear");
        chk("mc.busy0", bus.sb_busy, 32'd0);

        // WAW, then same-cycle clear and set of r4
        issue_mc(5'd4); #1; check("waw.first"); tick();
        issue_mc(5'd4); #1; check("waw.stall");
        chk("waw.why", 32'(bus.stall_why), 32'b100);
        tick();
        bus.mc_done = 1; bus.mc_rd = 5'd4;
        #1; check("waw.setclr"); tick();
        chk("waw.keep", bus.sb_busy, 32'h10);

        // Flush while stalled
        issue_mc(5'd3); #1; check("fl.i3"); tick();
        issue_mc(5'd12); #1; check("fl.i12"); tick();
        idle(); bus.id_valid = 1; bus.src_rs = {5'd0, 5'd12}; bus.src_use = 2'b01;
        #1; check("fl.stall"); tick();
        bus.mc_flush = 1; #1; check("fl.flush"); tick();
        bus.mc_flush = 0; #1; check("fl.after");
        chk("fl.busy0", bus.sb_busy, 32'd0);
        tick();

        // Reset while stalled
        issue_mc(5'd3); #1; check("rs.issue"); tick();
        idle(); bus.id_valid = 1; bus.src_rs = {5'd3, 5'd0}; bus.src_use = 2'b10;
        #1; check("rs.stall"); tick(); tick();
        rst = 1; #1; check("rs.during"); tick();
        rst = 0; #1; check("rs.after");
        chk("rs.cnt0", bus.stall_cnt, 32'd0);

        // Watchdog
        issue_mc(5'd2); #1; check("wd.issue"); tick();
        idle();
        for (int k = 0; k < TIMEOUT + 1; k++) begin
            #1; check("wd.wait"); tick();
        end
        chk("wd.err", 32'(bus.sb_err), 32'd1);
        bus.mc_done = 1; bus.mc_rd = 5'd2; #1; check("wd.done"); tick();
        idle(); #1; check("wd.sticky");

        // Randomized traffic on a small register window
        rst = 1; tick(); rst = 0;
        for (int n = 0; n < 400; n++) begin
            bus.stg_wr   = 3'($urandom);
            bus.stg_rd   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            bus.stg_rdy  = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
            bus.stg_data = {$urandom, $urandom, $urandom};
            bus.src_rs   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            bus.src_use  = 2'($urandom);
            bus.src_rf   = {$urandom, $urandom};
            bus.id_valid = 1'($urandom);
            bus.id_wr    = 1'($urandom);
            bus.id_rd    = 5'($urandom_range(0, 7));
            bus.id_mc    = 1'($urandom);
            bus.mc_done  = ($urandom_range(0, 3) == 0);
            bus.mc_rd    = 5'($urandom_range(0, 7));
            bus.mc_data  = $urandom;
            bus.mc_flush = ($urandom_range(0, 39) == 0);
            rst          = ($urandom_range(0, 99) == 0);
            #1; check("rand");
            tick();
        end
        rst = 0;

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
`default_nettype wire
